// File: rtl/gol_pkg.sv
// gol_pkg: types and constants shared by the Game of Life grid-side blocks.
//   gol_state_e : serializer FSM states
//   GOL_M/N     : default grid columns/rows
//   GOL_BEAT_W  : default cells per output beat
//   gol_idx()   : flat bit index of cell (x,y) in the row-major grid vector
package gol_pkg;

    typedef enum logic {
        GOL_IDLE   = 1'b0,
        GOL_STREAM = 1'b1
    } gol_state_e;

    localparam int GOL_M      = 16;
    localparam int GOL_N      = 16;
    localparam int GOL_BEAT_W = 4;

    function automatic int gol_idx(input int x, input int y, input int m);
        return y * m + x;
    endfunction

endpackage

// File: rtl/gol_frame_serializer_if.sv
// gol_frame_serializer_if: valid/ready beat stream carrying grid cells.
//   valid/ready : handshake (beat moves when both are high at a rising edge)
//   data        : BEAT_W cells of one row, lowest column in bit 0
//   sof/eof     : first/last beat of the frame
//   sol/eol     : first/last beat of a row
// master = producer (serializer), slave = sink.
interface gol_frame_serializer_if
    import gol_pkg::*;
#(
    parameter int BEAT_W = GOL_BEAT_W
) ();
    logic              valid;
    logic              ready;
    logic [BEAT_W-1:0] data;
    logic              sof;
    logic              eof;
    logic              sol;
    logic              eol;

    modport master (output valid, data, sof, eof, sol, eol, input ready);
    modport slave  (input valid, data, sof, eof, sol, eol, output ready);
endinterface

// File: rtl/gol_xy_counter.sv
// gol_xy_counter: column/row position counter for walking a grid.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : return to (0,0); wins over adv_i
//   adv_i          : step one position (x first, then y)
//   x_o, y_o       : current position
//   x_last_o       : x is at its last value
//   y_last_o       : y is at its last value
// Stepping past (last,last) wraps to (0,0).
module gol_xy_counter
    import gol_pkg::*;
#(
    parameter int X_CNT = 4,
    parameter int Y_CNT = 16,
    parameter int XW    = (X_CNT > 1) ? $clog2(X_CNT) : 1,
    parameter int YW    = (Y_CNT > 1) ? $clog2(Y_CNT) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          x_last_o,
    output logic          y_last_o
);
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign x_last_o = (x_q == XW'(X_CNT - 1));
    assign y_last_o = (y_q == YW'(Y_CNT - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (x_last_o) begin
                x_d = '0;
                y_d = y_last_o ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/gol_frame_serializer.sv
// gol_frame_serializer: snapshots the flattened grid on request and streams it
// out row by row as BEAT_W-cell beats.
//   clk_i, reset_i : clock, synchronous active-high reset
//   state_i        : grid, cell (x,y) at bit y*M+x
//   frame_req_i    : snapshot request (honoured only when idle)
//   busy_o         : frame in progress
//   req_drop_o     : pulse, a request arrived while busy and was ignored
//   frame_done_o   : pulse, the cycle after the last beat was accepted
//   frame_cnt_o    : completed frames, wraps
//   m              : beat stream (master side)
module gol_frame_serializer
    import gol_pkg::*;
#(
    parameter int M      = GOL_M,
    parameter int N      = GOL_N,
    parameter int BEAT_W = GOL_BEAT_W,
    parameter int CNT_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [N*M-1:0]         state_i,
    input  logic                   frame_req_i,
    output logic                   busy_o,
    output logic                   req_drop_o,
    output logic                   frame_done_o,
    output logic [CNT_W-1:0]       frame_cnt_o,
    gol_frame_serializer_if.master m
);
    localparam int BPR   = M / BEAT_W;
    localparam int BX_W  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int Y_W   = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = $clog2(N * M);

    gol_state_e       state_q, state_d;
    logic [N*M-1:0]   snap_q;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start;
    logic             hs;
    logic             streaming;

    logic [BX_W-1:0]   bx;
    logic [Y_W-1:0]    by;
    logic              bx_last;
    logic              by_last;
    logic [IDX_W-1:0]  beat_base;
    logic [BEAT_W-1:0] beat_data;

    gol_xy_counter #(
        .X_CNT (BPR),
        .Y_CNT (N),
        .XW    (BX_W),
        .YW    (Y_W)
    ) u_xy (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (start),
        .adv_i    (hs),
        .x_o      (bx),
        .y_o      (by),
        .x_last_o (bx_last),
        .y_last_o (by_last)
    );

    assign streaming = (state_q == GOL_STREAM);
    assign hs        = streaming && m.ready;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            GOL_IDLE: begin
                if (frame_req_i) begin
                    state_d = GOL_STREAM;
                    start   = 1'b1;
                end
            end
            GOL_STREAM: begin
                // Any request during a frame is dropped, even on the final
                // handshake; the block only re-arms once it is back in IDLE.
                drop_d = frame_req_i;
                if (hs && bx_last && by_last) begin
                    state_d = GOL_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = GOL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= GOL_IDLE;
            snap_q  <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            if (start) begin
                snap_q <= state_i;
            end
        end
    end

    // Beat mux: cells bx*BEAT_W .. bx*BEAT_W+BEAT_W-1 of row by.
    always_comb begin
        beat_base = IDX_W'(gol_idx(int'(bx) * BEAT_W, int'(by), M));
    end

    generate
        for (genvar gi = 0; gi < BEAT_W; gi++) begin : g_beat
            assign beat_data[gi] = snap_q[beat_base + IDX_W'(gi)];
        end
    endgenerate

    // Data and markers are forced low outside a frame so the idle/reset bus
    // is all zeros.
    assign m.valid = streaming;
    assign m.data  = streaming ? beat_data : '0;
    assign m.sol   = streaming && (bx == '0);
    assign m.eol   = streaming && bx_last;
    assign m.sof   = streaming && (bx == '0) && (by == '0);
    assign m.eof   = streaming && bx_last && by_last;

    assign busy_o       = streaming;
    assign req_drop_o   = drop_q;
    assign frame_done_o = done_q;
    assign frame_cnt_o  = cnt_q;
endmodule

// File: tb/tb_gol_frame_serializer.sv
module tb_gol_frame_serializer;
    localparam int M      = 16;
    localparam int N      = 16;
    localparam int BEAT_W = 4;
    localparam int BEATS  = N * M / BEAT_W;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              sof;
        logic              eof;
        logic              sol;
        logic              eol;
    } beat_t;

    typedef struct {
        logic [N*M-1:0] grid;
        int             ready_pct;
        bit             scramble;
        int             req_at_beat;
        bit             chk_glider;
        logic [3:0]     exp_b4;
        logic [3:0]     exp_b8;
        logic [3:0]     exp_b12;
        int             exp_drops;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N*M-1:0] state_i;
    logic           frame_req_i;
    logic           busy_o;
    logic           req_drop_o;
    logic           frame_done_o;
    logic [15:0]    frame_cnt_o;

    gol_frame_serializer_if #(.BEAT_W(BEAT_W)) m ();

    gol_frame_serializer #(.M(M), .N(N), .BEAT_W(BEAT_W), .CNT_W(16)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .state_i      (state_i),
        .frame_req_i  (frame_req_i),
        .busy_o       (busy_o),
        .req_drop_o   (req_drop_o),
        .frame_done_o (frame_done_o),
        .frame_cnt_o  (frame_cnt_o),
        .m            (m)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    ready_pct = 100;
    int    beats_seen = 0;
    int    done_cnt = 0;
    int    drop_cnt = 0;
    int    done_cyc = 0;
    int    exp_frames = 0;
    beat_t exp_q[$];
    logic [BEAT_W-1:0] beat_log[BEATS];
    logic [N*M-1:0] glider;
    vec_t  vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference beat stream for a grid, straight from the cell addressing rule.
    task automatic push_frame(input logic [N*M-1:0] g);
        beat_t b;
        for (int k = 0; k < BEATS; k++) begin
            int row = k / (M / BEAT_W);
            int col = k % (M / BEAT_W);
            for (int j = 0; j < BEAT_W; j++) b.data[j] = g[row * M + col * BEAT_W + j];
            b.sof = (k == 0);
            b.eof = (k == BEATS - 1);
            b.sol = (col == 0);
            b.eol = (col == M / BEAT_W - 1);
            exp_q.push_back(b);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m.ready = ($urandom_range(99, 0) < ready_pct);
    end

    // Monitor: scoreboard compare on every handshake, stall-stability check,
    // pulse counting.
    initial begin
        bit    stall_prev = 1'b0;
        beat_t prev_b;
        beat_t cur_b;
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset_i !== 1'b0) begin
                stall_prev = 1'b0;
            end else begin
                cur_b = '{m.data, m.sof, m.eof, m.sol, m.eol};
                if (stall_prev) begin
                    check("stall_valid_held", m.valid, 1);
                    check("stall_beat_stable", cur_b, prev_b);
                end
                if (m.valid && m.ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m.data, e.data);
                        check("beat_markers", {m.sof, m.eof, m.sol, m.eol}, {e.sof, e.eof, e.sol, e.eol});
                    end
                    if (beats_seen < BEATS) beat_log[beats_seen] = m.data;
                    beats_seen++;
                end
                stall_prev = m.valid && !m.ready;
                prev_b     = cur_b;
                if (frame_done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (req_drop_o) drop_cnt++;
            end
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (frame_done_o) ok = 1'b1;
        end
    endtask

    task automatic run_frame(input vec_t v);
        int c0;
        int drops0 = drop_cnt;
        int dones0 = done_cnt;
        bit done = 1'b0;
        bit req_sent = 1'b0;
        state_i   = v.grid;
        ready_pct = v.ready_pct;
        push_frame(v.grid);
        beats_seen = 0;
        @(posedge clk); #1;
        frame_req_i = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        frame_req_i = 1'b0;
        check("first_valid", m.valid, 1);
        check("first_sof", m.sof, 1);
        for (int t = 0; t < 3000 && !done; t++) begin
            if (v.scramble) state_i = {$urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom};
            if (v.req_at_beat >= 0 && !req_sent && beats_seen >= v.req_at_beat) begin
                frame_req_i = 1'b1;
                req_sent    = 1'b1;
            end else begin
                frame_req_i = 1'b0;
            end
            @(negedge clk);
            if (frame_done_o) done = 1'b1;
            @(posedge clk); #1;
        end
        frame_req_i = 1'b0;
        exp_frames++;
        check("frame_completed", done, 1);
        if (v.ready_pct == 100) check("frame_latency", done_cyc - c0, BEATS + 1);
        check("beats_left", exp_q.size(), 0);
        check("beat_count", beats_seen, BEATS);
        check("done_pulses", done_cnt - dones0, 1);
        check("drop_pulses", drop_cnt - drops0, v.exp_drops);
        check("frame_cnt", frame_cnt_o, exp_frames);
        check("busy_after", busy_o, 0);
        if (v.chk_glider) begin
            check("glider_b4", beat_log[4], v.exp_b4);
            check("glider_b8", beat_log[8], v.exp_b8);
            check("glider_b12", beat_log[12], v.exp_b12);
        end
        exp_q.delete();
    endtask

    initial begin
        bit ok;
        int vcount;
        int dones0;
        int drops0;
        logic [N*M-1:0] g2;

        glider = '0;
        glider[1 * M + 2] = 1'b1;
        glider[2 * M + 3] = 1'b1;
        glider[3 * M + 1] = 1'b1;
        glider[3 * M + 2] = 1'b1;
        glider[3 * M + 3] = 1'b1;

        vecs[0] = '{glider, 100, 1'b0, -1, 1'b1, 4'b0100, 4'b1000, 4'b1110, 0};
        vecs[1] = '{glider, 50, 1'b0, -1, 1'b1, 4'b0100, 4'b1000, 4'b1110, 0};
        vecs[2] = '{{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    100, 1'b1, 30, 1'b0, 4'b0, 4'b0, 4'b0, 1};
        vecs[3] = '{{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    40, 1'b1, 30, 1'b0, 4'b0, 4'b0, 4'b0, 1};

        // Reset and idle.
        reset_i     = 1'b1;
        frame_req_i = 1'b0;
        state_i     = glider;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_valid", m.valid, 0);
        check("rst_data", m.data, 0);
        check("rst_markers", {m.sof, m.eof, m.sol, m.eol}, 0);
        check("rst_done", frame_done_o, 0);
        check("rst_drop", req_drop_o, 0);
        check("rst_cnt", frame_cnt_o, 0);
        reset_i = 1'b0;
        vcount  = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (m.valid !== 1'b0 || busy_o !== 1'b0) vcount++;
        end
        check("idle_no_valid", vcount, 0);

        // Table-driven frames.
        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Last-beat race: request on the final handshake is dropped, request in
        // the frame_done cycle starts the next frame.
        ready_pct = 100;
        state_i   = glider;
        g2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        push_frame(glider);
        push_frame(g2);
        drops0 = drop_cnt;
        @(posedge clk); #1;
        frame_req_i = 1'b1;
        @(posedge clk); #1;
        frame_req_i = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (m.valid && m.eof) ok = 1'b1;
        end
        check("race_reached_eof", ok, 1);
        frame_req_i = 1'b1;
        state_i     = g2;
        @(posedge clk); #1;
        check("race_done_pulse", frame_done_o, 1);
        check("race_drop_pulse", req_drop_o, 1);
        check("race_idle_valid", m.valid, 0);
        @(posedge clk); #1;
        frame_req_i = 1'b0;
        check("race_restart_valid", m.valid, 1);
        check("race_restart_sof", m.sof, 1);
        check("race_no_second_drop", req_drop_o, 0);
        state_i = '0;
        wait_done(ok);
        exp_frames += 2;
        check("race_frame2_done", ok, 1);
        check("race_beats_left", exp_q.size(), 0);
        check("race_frame_cnt", frame_cnt_o, exp_frames);
        check("race_drops", drop_cnt - drops0, 1);
        exp_q.delete();

        // Reset mid-frame.
        ready_pct = 100;
        state_i   = glider;
        push_frame(glider);
        beats_seen = 0;
        @(posedge clk); #1;
        frame_req_i = 1'b1;
        @(posedge clk); #1;
        frame_req_i = 1'b0;
        for (int t = 0; t < 200 && beats_seen < 20; t++) begin
            @(posedge clk); #1;
        end
        check("rstmid_reached_beat20", beats_seen >= 20, 1);
        dones0  = done_cnt;
        reset_i = 1'b1;
        frame_req_i = 1'b1;
        @(posedge clk); #1;
        frame_req_i = 1'b0;
        check("rstmid_valid", m.valid, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_cnt", frame_cnt_o, 0);
        exp_q.delete();
        exp_frames = 0;
        @(posedge clk); #1;
        reset_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_no_done", done_cnt - dones0, 0);
        check("rstmid_still_idle", m.valid, 0);
        run_frame(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
